// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from the output FIFO and serialises them as 8N1
// UART frames, least significant byte first, back-to-back within a word.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enabled,
  output logic                  tx,
  output logic                  busy,
  output logic                  word_done
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [BW-1:0]         byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  word_done_q, word_done_d;
  logic                  timer_end;

  // The word is shifted right one bit per data bit, so after eight data bits
  // the next byte of the word already sits in the low bits.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    word_done_d = 1'b0;
    timer_end   = (timer_q == TIMER_LAST);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d    = fifo_data_out;
        byte_idx_d = '0;
        timer_d    = '0;
        state_d    = START;
      end
      START: begin
        if (timer_end) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_end) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_end) begin
          timer_d = '0;
          if (byte_idx_q != BYTE_LAST) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = START;
          end else begin
            word_done_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    rd_en_d = (state_d == POP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

  assign tx                = tx_q;
  assign fifo_read_enabled = rd_en_q;
  assign busy              = busy_q;
  assign word_done         = word_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a behavioural FIFO and compares the
// tx line cycle by cycle against frames built directly from the 8N1 rules.
module tb_fifo_uart_tx;

  localparam int DW    = 16;
  localparam int CPB   = 4;
  localparam int BYTES = DW / 8;
  localparam int WORDC = BYTES * 10 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_enabled;
  logic          tx;
  logic          busy;
  logic          word_done;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] fifoMem[$];
  logic          expStream[$];

  int   popCount = 0;
  int   doneCount = 0;
  int   consecRd = 0;
  int   rdWhileBusy = 0;
  int   rdWhileEmpty = 0;
  logic prevRd = 1'b0;
  logic prevBusy = 1'b0;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_data_out    (fifo_data_out),
    .fifo_empty       (fifo_empty),
    .fifo_read_enabled(fifo_read_enabled),
    .tx               (tx),
    .busy             (busy),
    .word_done        (word_done)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: data appears the cycle after the read enable is sampled.
  always @(posedge clk) begin
    if (fifo_read_enabled) begin
      if (fifo_empty) rdWhileEmpty++;
      else fifo_data_out <= fifoMem.pop_front();
    end
  end

  always @(negedge clk) fifo_empty = (fifoMem.size() == 0);

  always @(negedge clk) begin
    if (fifo_read_enabled) popCount++;
    if (word_done) doneCount++;
    if (fifo_read_enabled && prevRd) consecRd++;
    if (fifo_read_enabled && prevBusy) rdWhileBusy++;
    prevRd   = fifo_read_enabled;
    prevBusy = busy;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] w);
    @(posedge clk);
    #2;
    fifoMem.push_back(w);
  endtask

  // One word as a tx waveform: per byte (low byte first) start, 8 data bits
  // LSB first, stop, each held for CPB cycles.
  function automatic void addWord(input logic [DW-1:0] w);
    logic [7:0] by;
    for (int b = 0; b < BYTES; b++) begin
      by = 8'(w >> (8 * b));
      for (int c = 0; c < CPB; c++) expStream.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < CPB; c++) expStream.push_back(by[i]);
      for (int c = 0; c < CPB; c++) expStream.push_back(1'b1);
    end
  endfunction

  function automatic void addGap();
    for (int c = 0; c < 3; c++) expStream.push_back(1'b1);
  endfunction

  // Waits (bounded) for the start bit, then compares n cycles of tx.
  task automatic captureStream(input string tag, input int n, output int popAt,
                               output int fallAt);
    int waitCyc = 0;
    int mism = 0;
    popAt  = -1;
    do begin
      @(negedge clk);
      waitCyc++;
      if (fifo_read_enabled && popAt < 0) popAt = waitCyc;
    end while (tx !== 1'b0 && waitCyc < 40);
    fallAt = waitCyc;
    checkOutput({tag, " startFound"}, 32'(tx === 1'b0), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= expStream.size() || tx !== expStream[i]) mism++;
    end
    checkOutput({tag, " txStream"}, mism, 0);
  endtask

  initial begin
    int viol;
    int popBase;
    int doneBase;
    int popAt;
    int fallAt;
    logic [DW-1:0] rw[4];

    // Reset held for one edge, then a long idle stretch with an empty FIFO.
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset tx", tx, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset rd", fifo_read_enabled, 0);
    checkOutput("reset done", word_done, 0);
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_enabled !== 1'b0) viol++;
    end
    checkOutput("idle hold", viol, 0);

    // Single word with pop-to-start latency.
    popBase  = popCount;
    doneBase = doneCount;
    expStream.delete();
    addWord(16'h41A5);
    applyStimulus(16'h41A5);
    captureStream("word41A5", WORDC, popAt, fallAt);
    checkOutput("pop to fall latency", 32'(fallAt - popAt), 32'd2);
    repeat (3) @(negedge clk);
    checkOutput("word41A5 pops", popCount - popBase, 1);
    checkOutput("word41A5 done", doneCount - doneBase, 1);
    checkOutput("word41A5 busy", busy, 0);
    checkOutput("word41A5 empty", fifo_empty, 1);

    // Two queued words: 3 idle-high cycles between them.
    popBase  = popCount;
    doneBase = doneCount;
    expStream.delete();
    addWord(16'h0001);
    addGap();
    addWord(16'hFF00);
    fifoMem.push_back(16'h0001);
    fifoMem.push_back(16'hFF00);
    captureStream("backToBack", 2 * WORDC + 3, popAt, fallAt);
    repeat (3) @(negedge clk);
    checkOutput("backToBack pops", popCount - popBase, 2);
    checkOutput("backToBack done", doneCount - doneBase, 2);
    checkOutput("backToBack tx idle", tx, 1);

    // Reset in the middle of a frame aborts it; the next word is clean.
    popBase = popCount;
    expStream.delete();
    addWord(16'h1234);
    applyStimulus(16'h1234);
    captureStream("abort prefix", 20, popAt, fallAt);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort tx", tx, 1);
    checkOutput("abort busy", busy, 0);
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    checkOutput("abort quiet", viol, 0);
    checkOutput("abort pops", popCount - popBase, 1);
    expStream.delete();
    addWord(16'h00AA);
    applyStimulus(16'h00AA);
    captureStream("after abort", WORDC, popAt, fallAt);

    // Random words: three queued, a fourth pushed while the first is on the line.
    repeat (3) @(negedge clk);
    popBase  = popCount;
    doneBase = doneCount;
    expStream.delete();
    for (int i = 0; i < 4; i++) begin
      rw[i] = DW'($urandom);
      if (i > 0) addGap();
      addWord(rw[i]);
    end
    fifoMem.push_back(rw[0]);
    fifoMem.push_back(rw[1]);
    fifoMem.push_back(rw[2]);
    fork
      captureStream("random4", 4 * WORDC + 9, popAt, fallAt);
      begin
        repeat (30) @(negedge clk);
        applyStimulus(rw[3]);
      end
    join
    repeat (3) @(negedge clk);
    checkOutput("random4 pops", popCount - popBase, 4);
    checkOutput("random4 done", doneCount - doneBase, 4);

    // FIFO already non-empty while reset is held: no pop until release.
    @(negedge clk);
    rst = 1'b1;
    popBase = popCount;
    expStream.delete();
    for (int i = 0; i < 3; i++) begin
      rw[i] = DW'($urandom);
      if (i > 0) addGap();
      addWord(rw[i]);
      applyStimulus(rw[i]);
    end
    repeat (2) @(negedge clk);
    checkOutput("reset blocks pop", popCount - popBase, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first pop after release", fifo_read_enabled, 1);
    captureStream("heldNonEmpty", 3 * WORDC + 6, popAt, fallAt);
    repeat (3) @(negedge clk);
    checkOutput("heldNonEmpty pops", popCount - popBase, 3);

    checkOutput("rd never consecutive", consecRd, 0);
    checkOutput("rd never while busy", rdWhileBusy, 0);
    checkOutput("rd never while empty", rdWhileEmpty, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
